// File: rtl/datapath_pkg.sv
// -----------------------------------------------------------------------------
// datapath_pkg
// Shared definitions for the datapath block: control-word field positions,
// ALU opcodes, operand source indices and the output destination index.
// Related build option: DATAPATH_FLAGS_EN (see datapath.sv).
// -----------------------------------------------------------------------------
package datapath_pkg;

   // Control word layout: [14:13] op, [12:9] src A, [8:5] src B, [4:1] dst, [0] w
   localparam int CTL_W     = 15;
   localparam int ALU_HI    = 14;
   localparam int ALU_LO    = 13;
   localparam int SRCA_HI   = 12;
   localparam int SRCA_LO   = 9;
   localparam int SRCB_HI   = 8;
   localparam int SRCB_LO   = 5;
   localparam int DST_HI    = 4;
   localparam int DST_LO    = 1;
   localparam int WEN_BIT   = 0;

   localparam int NUM_REGS  = 8;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_op_e;

   // Operand source indices above the register file
   localparam logic [3:0] SRC_IN   = 4'd8;
   localparam logic [3:0] SRC_ZERO = 4'd9;
   localparam logic [3:0] SRC_ONE  = 4'd10;
   localparam logic [3:0] SRC_RES  = 4'd11;

   // Destination index that targets the output register
   localparam logic [3:0] DST_OUT  = 4'd8;

endpackage

// File: rtl/datapath_alu.sv
// -----------------------------------------------------------------------------
// datapath_alu
// Purely combinational ALU: add, subtract, AND, OR on WIDTH-bit operands.
// Ports:
//   i_a, i_b   operands (WIDTH)
//   i_op       operation (2 bits, datapath_pkg::alu_op_e encoding)
//   o_result   WIDTH-bit result, wraps modulo 2^WIDTH
//   o_carry    add: carry-out; sub: borrow (A < B unsigned); logic ops: 0
// -----------------------------------------------------------------------------
module datapath_alu
   import datapath_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [1:0]       i_op,
   output logic [WIDTH-1:0] o_result,
   output logic             o_carry
);

   logic [WIDTH:0] w_ext;

   always_comb begin
      w_ext = '0;
      case (alu_op_e'(i_op))
         ALU_ADD: w_ext = {1'b0, i_a} + {1'b0, i_b};
         // The extra MSB of a widened subtract is set exactly when A < B
         ALU_SUB: w_ext = {1'b0, i_a} - {1'b0, i_b};
         ALU_AND: w_ext = {1'b0, i_a & i_b};
         ALU_OR:  w_ext = {1'b0, i_a | i_b};
         default: w_ext = '0;
      endcase
   end

   assign o_result = w_ext[WIDTH-1:0];
   assign o_carry  = w_ext[WIDTH];

endmodule

// File: rtl/datapath.sv
// -----------------------------------------------------------------------------
// datapath
// Eight-entry register file, two operand muxes, an ALU and an output register,
// driven by a 15-bit control word every cycle.
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-low reset
//   i_signal  control word {op[1:0], srcA[3:0], srcB[3:0], dst[3:0], w}
//   i_data    external operand (source index 8)
//   o_data    output register (destination index 8)
//   o_valid   high the cycle after o_data was written
//   o_result  ALU result registered every cycle
//   o_carry   registered carry/borrow flag
//   o_zero    registered zero flag
// Build option: define DATAPATH_FLAGS_EN to implement the flag registers;
// otherwise o_carry and o_zero are tied to 0.
// -----------------------------------------------------------------------------
module datapath
   import datapath_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [14:0]      i_signal,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_result,
   output logic             o_carry,
   output logic             o_zero
);

   logic [WIDTH-1:0] r_regs [NUM_REGS];
   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic [WIDTH-1:0] r_result;

   logic [1:0]       w_op;
   logic [3:0]       w_srca;
   logic [3:0]       w_srcb;
   logic [3:0]       w_dst;
   logic             w_wen;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_alu_res;
   logic             w_alu_carry;
   logic             w_wr_reg;
   logic             w_wr_out;

   assign w_op   = i_signal[ALU_HI:ALU_LO];
   assign w_srca = i_signal[SRCA_HI:SRCA_LO];
   assign w_srcb = i_signal[SRCB_HI:SRCB_LO];
   assign w_dst  = i_signal[DST_HI:DST_LO];
   assign w_wen  = i_signal[WEN_BIT];

   // Destinations 9-15 are null: nothing but o_result changes
   assign w_wr_reg = w_wen && (w_dst < DST_OUT);
   assign w_wr_out = w_wen && (w_dst == DST_OUT);

   function automatic logic [WIDTH-1:0] sel_src(input logic [3:0] idx);
      logic [WIDTH-1:0] v;
      v = '0;
      if (idx < SRC_IN)
         v = r_regs[idx[2:0]];
      else if (idx == SRC_IN)
         v = i_data;
      else if (idx == SRC_ONE)
         v = WIDTH'(1);
      else if (idx == SRC_RES)
         v = r_result;
      return v;
   endfunction

   // Combinational reads see the pre-edge contents, so a same-cycle write
   // only becomes visible on the following cycle
   assign w_a = sel_src(w_srca);
   assign w_b = sel_src(w_srcb);

   datapath_alu #(.WIDTH(WIDTH)) u_alu (
      .i_a      (w_a),
      .i_b      (w_b),
      .i_op     (w_op),
      .o_result (w_alu_res),
      .o_carry  (w_alu_carry)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < NUM_REGS; k++)
            r_regs[k] <= '0;
         r_data   <= '0;
         r_valid  <= 1'b0;
         r_result <= '0;
      end else begin
         r_result <= w_alu_res;
         r_valid  <= w_wr_out;
         if (w_wr_reg)
            r_regs[w_dst[2:0]] <= w_alu_res;
         if (w_wr_out)
            r_data <= w_alu_res;
      end
   end

   assign o_data   = r_data;
   assign o_valid  = r_valid;
   assign o_result = r_result;

`ifdef DATAPATH_FLAGS_EN
   logic r_carry;
   logic r_zero;

   // Flags follow real writes only (register file or output register)
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_carry <= 1'b0;
         r_zero  <= 1'b0;
      end else if (w_wr_reg || w_wr_out) begin
         r_carry <= w_alu_carry;
         r_zero  <= (w_alu_res == '0);
      end
   end

   assign o_carry = r_carry;
   assign o_zero  = r_zero;
`else
   logic w_unused_carry;
   assign w_unused_carry = w_alu_carry;
   assign o_carry = 1'b0;
   assign o_zero  = 1'b0;
`endif

endmodule
